// File: rtl/mm_row_fetch.sv
// mm_row_fetch: fetches one ROWS x N matrix row from synchronous-read memory and streams it
// through a 2-entry FIFO. Defining MM_ROW_CHECKSUM_EN adds the per-row element-sum output.
module mm_row_fetch #(
    parameter int DATA_W = 16,
    parameter int N      = 16,
    parameter int ROWS   = 16,
    parameter int ADDR_W = $clog2(ROWS*N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       row_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef MM_ROW_CHECKSUM_EN
    ,
    output logic [DATA_W+$clog2(N)-1:0] checksum
`endif
);

    localparam int COL_W = $clog2(N);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  rd_col;
    logic [COL_W-1:0]  out_col;
    logic              rd_pend;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              err_q;

    logic              row_ok;
    logic              accept;
    logic              pop;
    logic [2:0]        occ;
    logic              issue;
    logic [ADDR_W-1:0] rd_addr;

    // Occupancy counts this cycle's pop so a full-rate stream keeps one read per cycle.
    always_comb begin
        row_ok  = row_sel < 32'(ROWS);
        accept  = (state == S_IDLE) && start && row_ok;
        pop     = out_valid && out_ready;
        occ     = {1'b0, count} + {2'b00, rd_pend} - {2'b00, pop};
        issue   = (state == S_FETCH) && (occ < 3'd2);
        rd_addr = (ADDR_W'(row) << COL_W) | ADDR_W'(rd_col);
    end

    assign mem_rd_en = issue;
    assign mem_addr  = issue ? rd_addr : '0;
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign out_last  = out_valid && (out_col == COL_W'(N-1));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            row         <= '0;
            rd_col      <= '0;
            out_col     <= '0;
            rd_pend     <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q   <= (state == S_IDLE) && start && !row_ok;
            rd_pend <= issue;
            count   <= count + {1'b0, rd_pend} - {1'b0, pop};

            // Read data is written one cycle after its strobe; rd_pend is cleared by reset,
            // so data returning for a read issued before reset is dropped.
            if (rd_pend) begin
                fifo_mem[wr_ptr] <= mem_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_col <= out_col + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_FETCH;
                        row     <= row_sel[ROW_W-1:0];
                        rd_col  <= '0;
                        out_col <= '0;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        rd_col <= rd_col + 1'b1;
                        if (rd_col == COL_W'(N-1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && (out_col == COL_W'(N-1))) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MM_ROW_CHECKSUM_EN
    localparam int SUM_W = DATA_W + COL_W;

    logic [SUM_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            checksum <= '0;
        end else if (accept) begin
            acc      <= '0;
            checksum <= '0;
        end else if (pop) begin
            acc <= acc + SUM_W'(out_data);
            if ((state == S_DRAIN) && (out_col == COL_W'(N-1)))
                checksum <= acc + SUM_W'(out_data);
        end
    end
`endif

endmodule
